// File: rtl/melody_sequencer.sv
// Table-driven melody player: steps through a 16-entry note table, gating the tone
// decoder per note and waiting for a waveform period end before moving on.
module melody_sequencer #(
    parameter int TICK_DIV = 31500,
    parameter int UNIT_MS  = 50,
    parameter logic [191:0] MELODY = {
        {8{12'h000}},
        12'hB04, 12'h2C4, 12'h244, 12'h1C4, 12'h144, 12'h104, 12'h084, 12'h004
    }
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPlay,
    input  logic       stopPlay,
    input  logic       loopEn,
    input  logic       end_of_wave,
    output logic [3:0] tone,
    output logic       soundEnable,
    output logic       busy,
    output logic       noteStrobe,
    output logic       doneStrobe
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MS_MAX   = MW'(UNIT_MS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, WAIT_EOW} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [MW-1:0] ms_q, ms_d;
    logic [5:0]    unit_q, unit_d;
    logic [3:0]    tone_q, tone_d;
    logic          snd_q, snd_d;
    logic          note_q, note_d;
    logic          done_q, done_d;

    logic [11:0]   entry;
    logic          e_last;
    logic          e_rest;
    logic [5:0]    e_dur_max;

    assign entry     = MELODY[32'(idx_q) * 12 +: 12];
    assign e_rest    = entry[10];
    // Entry 15 always terminates the table so the index never wraps on its own.
    assign e_last    = entry[11] | (idx_q == 4'd15);
    assign e_dur_max = (entry[5:0] == 6'd0) ? 6'd0 : entry[5:0] - 6'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        ms_d    = ms_q;
        unit_d  = unit_q;
        tone_d  = tone_q;
        snd_d   = snd_q;
        note_d  = 1'b0;
        done_d  = 1'b0;

        if (stopPlay) begin
            state_d = IDLE;
            snd_d   = 1'b0;
            tick_d  = '0;
            ms_d    = '0;
            unit_d  = '0;
        end else if (startPlay) begin
            state_d = LOAD;
            idx_d   = 4'd0;
            tick_d  = '0;
            ms_d    = '0;
            unit_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: begin
                    state_d = PLAY;
                    tone_d  = entry[9:6];
                    snd_d   = ~e_rest;
                    note_d  = 1'b1;
                    tick_d  = '0;
                    ms_d    = '0;
                    unit_d  = '0;
                end
                // Note length is tick x ms x unit, each counter rolling into the next.
                PLAY: begin
                    if (tick_q == TICK_MAX) begin
                        tick_d = '0;
                        if (ms_q == MS_MAX) begin
                            ms_d = '0;
                            if (unit_q == e_dur_max) begin
                                unit_d  = '0;
                                state_d = WAIT_EOW;
                            end else begin
                                unit_d = unit_q + 6'd1;
                            end
                        end else begin
                            ms_d = ms_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAIT_EOW: begin
                    if (e_rest || end_of_wave || (tick_q == TICK_MAX)) begin
                        tick_d = '0;
                        if (!e_last) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = LOAD;
                        end else if (loopEn) begin
                            idx_d   = 4'd0;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            snd_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            tick_q  <= '0;
            ms_q    <= '0;
            unit_q  <= '0;
            tone_q  <= 4'd0;
            snd_q   <= 1'b0;
            note_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            unit_q  <= unit_d;
            tone_q  <= tone_d;
            snd_q   <= snd_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

    assign tone        = tone_q;
    assign soundEnable = snd_q;
    assign busy        = (state_q != IDLE);
    assign noteStrobe  = note_q;
    assign doneStrobe  = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a default-table and a custom-table instance share
// stimulus; a note-level model is compared every cycle plus directed scenarios.
module tb_melody_sequencer;
    localparam int TICK_DIV = 4;
    localparam int UNIT_MS  = 2;
    localparam int UNIT_CYC = TICK_DIV * UNIT_MS;
    localparam logic [191:0] MEL0 = {
        {8{12'h000}},
        12'hB04, 12'h2C4, 12'h244, 12'h1C4, 12'h144, 12'h104, 12'h084, 12'h004
    };
    localparam logic [191:0] MEL1 = {
        12'h3C2, 12'h381, 12'h341, 12'h301, 12'h2C1, 12'h281, 12'h241, 12'h201,
        12'h1C1, 12'h181, 12'h541, 12'h101, 12'h0C1, 12'h081, 12'h1C0, 12'h4C2
    };
    localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_WAIT = 3;

    logic clk = 1'b0;
    logic reset, startPlay, stopPlay, loopEn, end_of_wave;
    logic [3:0] tone0, tone1;
    logic snd0, snd1, busy0, busy1, note0, note1, done0, done1;

    int n_checks = 0;
    int n_pass = 0;

    logic [11:0] mel [2][16];
    int   m_mode [2];
    int   m_idx  [2];
    int   m_left [2];
    int   m_tone [2];
    int   m_snd  [2];
    int   m_note [2];
    int   m_done [2];
    bit   m_valid = 1'b0;

    always #5 clk = ~clk;

    melody_sequencer #(.TICK_DIV(TICK_DIV), .UNIT_MS(UNIT_MS)) dut0 (
        .clk(clk), .reset(reset), .startPlay(startPlay), .stopPlay(stopPlay),
        .loopEn(loopEn), .end_of_wave(end_of_wave), .tone(tone0),
        .soundEnable(snd0), .busy(busy0), .noteStrobe(note0), .doneStrobe(done0));

    melody_sequencer #(.TICK_DIV(TICK_DIV), .UNIT_MS(UNIT_MS), .MELODY(MEL1)) dut1 (
        .clk(clk), .reset(reset), .startPlay(startPlay), .stopPlay(stopPlay),
        .loopEn(loopEn), .end_of_wave(end_of_wave), .tone(tone1),
        .soundEnable(snd1), .busy(busy1), .noteStrobe(note1), .doneStrobe(done1));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Note-level model: each note is a countdown of whole cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [11:0] e;
            int dur;
            e = mel[k][m_idx[k]];
            m_note[k] = 0;
            m_done[k] = 0;
            if (reset) begin
                m_mode[k] = M_IDLE; m_idx[k] = 0; m_tone[k] = 0; m_snd[k] = 0;
            end else if (stopPlay) begin
                m_mode[k] = M_IDLE; m_snd[k] = 0;
            end else if (startPlay) begin
                m_mode[k] = M_LOAD; m_idx[k] = 0;
            end else if (m_mode[k] == M_LOAD) begin
                dur = (e[5:0] == 0) ? 1 : int'(e[5:0]);
                m_tone[k] = int'(e[9:6]);
                m_snd[k]  = e[10] ? 0 : 1;
                m_note[k] = 1;
                m_left[k] = dur * UNIT_CYC;
                m_mode[k] = M_PLAY;
            end else if (m_mode[k] == M_PLAY) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_mode[k] = M_WAIT;
                    m_left[k] = TICK_DIV;
                end
            end else if (m_mode[k] == M_WAIT) begin
                m_left[k]--;
                if (e[10] || end_of_wave || m_left[k] == 0) begin
                    if (!(e[11] || m_idx[k] == 15)) begin
                        m_idx[k]++; m_mode[k] = M_LOAD;
                    end else if (loopEn) begin
                        m_idx[k] = 0; m_mode[k] = M_LOAD;
                    end else begin
                        m_mode[k] = M_IDLE; m_snd[k] = 0; m_done[k] = 1;
                    end
                end
            end
        end
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tone0", int'(tone0), m_tone[0]);
            chk("snd0",  int'(snd0),  m_snd[0]);
            chk("busy0", int'(busy0), (m_mode[0] != M_IDLE) ? 1 : 0);
            chk("note0", int'(note0), m_note[0]);
            chk("done0", int'(done0), m_done[0]);
            chk("tone1", int'(tone1), m_tone[1]);
            chk("snd1",  int'(snd1),  m_snd[1]);
            chk("busy1", int'(busy1), (m_mode[1] != M_IDLE) ? 1 : 0);
            chk("note1", int'(note1), m_note[1]);
            chk("done1", int'(done1), m_done[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pulse();
        startPlay = 1'b1; tick(); startPlay = 1'b0;
    endtask

    task automatic stop_pulse();
        stopPlay = 1'b1; tick(); stopPlay = 1'b0;
    endtask

    initial begin
        int snd_cnt, notes, dones, gap, last_t, prev_t, found;
        int tones[$];
        for (int i = 0; i < 16; i++) begin
            mel[0][i] = MEL0[i*12 +: 12];
            mel[1][i] = MEL1[i*12 +: 12];
        end
        reset = 1'b1; startPlay = 1'b0; stopPlay = 1'b0; loopEn = 1'b0; end_of_wave = 1'b0;
        tick(); tick();
        chk("rst_tone", int'(tone0), 0);
        chk("rst_snd",  int'(snd0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_note", int'(note0), 0);
        chk("rst_done", int'(done0), 0);
        reset = 1'b0;

        // Full default melody, no loop, no end_of_wave.
        start_pulse();
        chk("lat_busy", int'(busy0), 1);
        chk("lat_note_early", int'(note0), 0);
        tick();
        chk("lat_note", int'(note0), 1);
        chk("lat_tone", int'(tone0), 0);
        chk("lat_snd",  int'(snd0), 1);
        snd_cnt = 1; notes = 1; dones = 0; tones.push_back(0);
        for (int i = 0; i < 400 && dones == 0; i++) begin
            tick();
            if (snd0) snd_cnt++;
            if (note0) begin notes++; tones.push_back(int'(tone0)); end
            if (done0) dones++;
        end
        chk("full_snd_cycles", snd_cnt, 7 * 37 + 36);
        chk("full_notes", notes, 8);
        chk("full_done", dones, 1);
        if (tones.size() == 8) begin
            chk("seq_t1", tones[1], 2);  chk("seq_t2", tones[2], 4);
            chk("seq_t3", tones[3], 5);  chk("seq_t4", tones[4], 7);
            chk("seq_t5", tones[5], 9);  chk("seq_t6", tones[6], 11);
            chk("seq_t7", tones[7], 12);
        end
        repeat (3) begin
            tick();
            if (done0) dones++;
        end
        chk("idle_busy", int'(busy0), 0);
        chk("idle_tone_hold", int'(tone0), 12);
        chk("single_done", dones, 1);

        // end_of_wave on the second WAIT_EOW cycle shortens note 0.
        start_pulse(); tick();
        repeat (33) tick();
        end_of_wave = 1'b1; tick(); end_of_wave = 1'b0;
        chk("eow_load_note", int'(note0), 0);
        chk("eow_load_busy", int'(busy0), 1);
        tick();
        chk("eow_next_note", int'(note0), 1);
        chk("eow_next_tone", int'(tone0), 2);
        stop_pulse();
        chk("stop_busy", int'(busy0), 0);
        chk("stop_snd", int'(snd0), 0);

        // Rest entry then zero-duration entry on the custom table.
        start_pulse(); tick();
        chk("rest_note", int'(note1), 1);
        chk("rest_tone", int'(tone1), 3);
        chk("rest_snd", int'(snd1), 0);
        gap = 0;
        for (int i = 1; i <= 40 && gap == 0; i++) begin tick(); if (note1) gap = i; end
        chk("rest_gap", gap, 18);
        chk("dur0_tone", int'(tone1), 7);
        chk("dur0_snd", int'(snd1), 1);
        gap = 0;
        for (int i = 1; i <= 40 && gap == 0; i++) begin tick(); if (note1) gap = i; end
        chk("dur0_gap", gap, 13);
        stop_pulse();

        // Looping through the last note.
        loopEn = 1'b1;
        start_pulse(); tick();
        notes = 1; dones = 0; last_t = int'(tone0); prev_t = -1;
        for (int i = 0; i < 400 && notes < 9; i++) begin
            tick();
            if (note0) begin notes++; prev_t = last_t; last_t = int'(tone0); end
            if (done0) dones++;
        end
        chk("loop_notes", notes, 9);
        chk("loop_prev", prev_t, 12);
        chk("loop_tone", last_t, 0);
        chk("loop_nodone", dones, 0);
        stop_pulse();
        chk("loop_stop_snd", int'(snd0), 0);
        chk("loop_stop_busy", int'(busy0), 0);
        loopEn = 1'b0;

        // Retrigger during note 5, start+stop together, reset mid-note.
        start_pulse();
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (note0 && tone0 == 4'd9) found = 1;
        end
        chk("note5_found", found, 1);
        repeat (3) tick();
        start_pulse();
        chk("retrig_hold", int'(tone0), 9);
        tick();
        chk("retrig_tone", int'(tone0), 0);
        chk("retrig_note", int'(note0), 1);
        gap = 0;
        for (int i = 1; i <= 60 && gap == 0; i++) begin tick(); if (note0) gap = i; end
        chk("retrig_gap", gap, 37);
        startPlay = 1'b1; stopPlay = 1'b1; tick(); startPlay = 1'b0; stopPlay = 1'b0;
        chk("both_busy", int'(busy0), 0);
        chk("both_snd", int'(snd0), 0);
        chk("both_done", int'(done0), 0);
        start_pulse(); tick(); repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rstmid_tone", int'(tone0), 0);
        chk("rstmid_snd", int'(snd0), 0);
        chk("rstmid_busy", int'(busy0), 0);
        chk("rstmid_note", int'(note0), 0);
        chk("rstmid_done", int'(done0), 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom % 500) == 0;
            startPlay   = ($urandom % 60) == 0;
            stopPlay    = ($urandom % 250) == 0;
            end_of_wave = ($urandom % 5) == 0;
            if (($urandom % 300) == 0) loopEn = ~loopEn;
            tick();
        end
        reset = 1'b0; startPlay = 1'b0; stopPlay = 1'b0; end_of_wave = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
